// File: rtl/uart_tx_arbiter.sv
`timescale 1ns/1ps
// Four-requester UART transmitter with a round-robin line lock: the owner keeps
// the line until it sends a newline/CR or stays silent for LOCK_TIMEOUT cycles.
//
// state   | meaning
// S_IDLE  | no lock owner, arbitrating among valid requesters
// S_WAIT  | owner holds the lock, serializer idle, timeout counting
// S_START | start bit (0) on TX
// S_DATA  | eight data bits on TX, LSB first
// S_STOP  | stop bit (1) on TX
module uart_tx_arbiter #(
    parameter int CLKS_PER_BIT = 868,
    parameter int LOCK_TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  req_valid,
    input  logic [31:0] req_data,
    output logic [3:0]  req_ready,
    output logic        TX,
    output logic [1:0]  grant_id,
    output logic        grant_active,
    output logic        busy
);

    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_START, S_DATA, S_STOP} state_t;

    localparam logic [15:0] BIT_LOAD = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] TO_LAST  = 16'(LOCK_TIMEOUT - 1);

    state_t      state_q;
    logic [1:0]  grant_id_q;
    logic        grant_active_q;
    logic [1:0]  rr_ptr_q;
    logic [7:0]  shift_q;
    logic [7:0]  byte_q;
    logic [15:0] bit_cnt_q;
    logic [2:0]  bit_idx_q;
    logic [15:0] to_cnt_q;
    logic        tx_q;

    logic [1:0]  pick;
    logic        pick_ok;
    logic        owner_valid;
    logic [7:0]  owner_data;

    // Walk offsets high to low so the nearest valid requester after rr_ptr wins.
    always_comb begin
        pick    = rr_ptr_q;
        pick_ok = 1'b0;
        for (int i = 3; i >= 0; i--) begin
            if (req_valid[rr_ptr_q + 2'(i)]) begin
                pick    = rr_ptr_q + 2'(i);
                pick_ok = 1'b1;
            end
        end
    end

    assign owner_valid = req_valid[grant_id_q];
    assign owner_data  = req_data[{grant_id_q, 3'b000} +: 8];

    always_comb begin
        req_ready = '0;
        if (state_q == S_WAIT) begin
            req_ready[grant_id_q] = 1'b1;
        end
    end

    assign TX           = tx_q;
    assign grant_id     = grant_id_q;
    assign grant_active = grant_active_q;
    assign busy         = (state_q == S_START) || (state_q == S_DATA) || (state_q == S_STOP);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            grant_id_q     <= 2'd0;
            grant_active_q <= 1'b0;
            rr_ptr_q       <= 2'd0;
            shift_q        <= 8'd0;
            byte_q         <= 8'd0;
            bit_cnt_q      <= 16'd0;
            bit_idx_q      <= 3'd0;
            to_cnt_q       <= 16'd0;
            tx_q           <= 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (pick_ok) begin
                        grant_id_q     <= pick;
                        grant_active_q <= 1'b1;
                        rr_ptr_q       <= pick + 2'd1;
                        to_cnt_q       <= 16'd0;
                        state_q        <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (owner_valid) begin
                        shift_q   <= owner_data;
                        byte_q    <= owner_data;
                        to_cnt_q  <= 16'd0;
                        bit_cnt_q <= BIT_LOAD;
                        tx_q      <= 1'b0;
                        state_q   <= S_START;
                    end else if (to_cnt_q == TO_LAST) begin
                        to_cnt_q       <= 16'd0;
                        grant_active_q <= 1'b0;
                        state_q        <= S_IDLE;
                    end else begin
                        to_cnt_q <= to_cnt_q + 16'd1;
                    end
                end
                S_START: begin
                    if (bit_cnt_q == 16'd0) begin
                        tx_q      <= shift_q[0];
                        shift_q   <= shift_q >> 1;
                        bit_idx_q <= 3'd0;
                        bit_cnt_q <= BIT_LOAD;
                        state_q   <= S_DATA;
                    end else begin
                        bit_cnt_q <= bit_cnt_q - 16'd1;
                    end
                end
                S_DATA: begin
                    if (bit_cnt_q == 16'd0) begin
                        bit_cnt_q <= BIT_LOAD;
                        if (bit_idx_q == 3'd7) begin
                            tx_q    <= 1'b1;
                            state_q <= S_STOP;
                        end else begin
                            tx_q      <= shift_q[0];
                            shift_q   <= shift_q >> 1;
                            bit_idx_q <= bit_idx_q + 3'd1;
                        end
                    end else begin
                        bit_cnt_q <= bit_cnt_q - 16'd1;
                    end
                end
                S_STOP: begin
                    if (bit_cnt_q == 16'd0) begin
                        to_cnt_q <= 16'd0;
                        if ((byte_q == 8'h0A) || (byte_q == 8'h0D)) begin
                            grant_active_q <= 1'b0;
                            state_q        <= S_IDLE;
                        end else begin
                            state_q <= S_WAIT;
                        end
                    end else begin
                        bit_cnt_q <= bit_cnt_q - 16'd1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
`timescale 1ns/1ps
// Scoreboard bench for uart_tx_arbiter: requester queues feed the DUT, a UART
// monitor decodes every frame on TX and checks it against the expected queue.
module tb_uart_tx_arbiter;

    localparam int CPB   = 4;
    localparam int LTO   = 16;
    localparam int FRAME = 10 * CPB;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic        TX;
    logic [1:0]  grant_id;
    logic        grant_active;
    logic        busy;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.CLKS_PER_BIT(CPB), .LOCK_TIMEOUT(LTO)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .TX           (TX),
        .grant_id     (grant_id),
        .grant_active (grant_active),
        .busy         (busy)
    );

    typedef struct packed {
        logic [1:0] id;
        logic [7:0] b;
    } exp_t;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];
    logic [7:0] sq0[$], sq1[$], sq2[$], sq3[$];

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, req);
        end
    endfunction

    function automatic void push_src(input int i, input logic [7:0] b);
        case (i)
            0: sq0.push_back(b);
            1: sq1.push_back(b);
            2: sq2.push_back(b);
            default: sq3.push_back(b);
        endcase
    endfunction

    function automatic int src_count(input int i);
        case (i)
            0: return sq0.size();
            1: return sq1.size();
            2: return sq2.size();
            default: return sq3.size();
        endcase
    endfunction

    function automatic logic [7:0] src_front(input int i);
        case (i)
            0: return sq0[0];
            1: return sq1[0];
            2: return sq2[0];
            default: return sq3[0];
        endcase
    endfunction

    function automatic void src_pop(input int i);
        case (i)
            0: void'(sq0.pop_front());
            1: void'(sq1.pop_front());
            2: void'(sq2.pop_front());
            default: void'(sq3.pop_front());
        endcase
    endfunction

    function automatic void push_exp(input logic [1:0] id, input logic [7:0] b);
        exp_t e;
        e.id = id;
        e.b  = b;
        exp_q.push_back(e);
    endfunction

    // Requester model: holds the queue head valid until a handshake pops it.
    initial begin : driver
        logic [3:0] fire;
        req_valid = 4'd0;
        req_data  = 32'd0;
        forever begin
            @(negedge clk);
            fire = req_valid & req_ready;
            @(posedge clk);
            #1;
            for (int i = 0; i < 4; i++) begin
                if (fire[i]) src_pop(i);
                if (src_count(i) > 0) begin
                    req_valid[i]       = 1'b1;
                    req_data[8*i +: 8] = src_front(i);
                end else begin
                    req_valid[i] = 1'b0;
                end
            end
        end
    end

    logic       samples[FRAME];
    int         ncyc;
    logic [1:0] frame_owner;
    logic [1:0] last_owner;
    bit         in_frame;
    bit         gap_valid;
    bit         lock_dropped;
    int         gap;

    function automatic void end_frame();
        logic       ok;
        logic [7:0] b;
        exp_t       e;
        chk("frame_len", ncyc, FRAME);
        ok = 1'b1;
        for (int k = 0; k < 10; k++)
            for (int j = 1; j < CPB; j++)
                if (samples[k*CPB+j] !== samples[k*CPB]) ok = 1'b0;
        if (samples[0] !== 1'b0) ok = 1'b0;
        if (samples[9*CPB] !== 1'b1) ok = 1'b0;
        chk("frame_shape", ok, 1);
        for (int k = 0; k < 8; k++) b[k] = samples[(k+1)*CPB];
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_frame: got owner %0d byte %02h, expected no frame", frame_owner, b);
        end else begin
            e = exp_q.pop_front();
            chk("frame_owner", frame_owner, e.id);
            chk("frame_byte", b, e.b);
        end
    endfunction

    initial begin : monitor
        in_frame     = 0;
        gap_valid    = 0;
        lock_dropped = 0;
        gap          = 0;
        ncyc         = 0;
        frame_owner  = 2'd0;
        last_owner   = 2'd0;
        forever begin
            @(negedge clk);
            if (rst_n !== 1'b1) begin
                in_frame  = 0;
                gap_valid = 0;
            end else if (busy === 1'b1) begin
                if (!in_frame) begin
                    in_frame    = 1;
                    ncyc        = 0;
                    frame_owner = grant_id;
                    if (gap_valid && frame_owner == last_owner && !lock_dropped)
                        chk("b2b_gap", gap, 1);
                end
                if (ncyc < FRAME) samples[ncyc] = TX;
                ncyc++;
            end else begin
                if (in_frame) begin
                    in_frame = 0;
                    end_frame();
                    gap_valid    = 1;
                    gap          = 0;
                    lock_dropped = 0;
                    last_owner   = frame_owner;
                end
                gap++;
                if (grant_active !== 1'b1) lock_dropped = 1;
            end
        end
    end

    // mode 0: busy high, 1: busy low, 2: everything drained and lock released
    task automatic wait_until(input int mode, input int budget, input string nm);
        int n;
        bit hit;
        n   = 0;
        hit = 0;
        while (!hit && n <= budget) begin
            @(negedge clk);
            n++;
            case (mode)
                0: hit = (busy === 1'b1);
                1: hit = (busy === 1'b0);
                default: hit = (grant_active === 1'b0) && (busy === 1'b0) && (exp_q.size() == 0) &&
                               (src_count(0) + src_count(1) + src_count(2) + src_count(3) == 0);
            endcase
        end
        if (!hit) begin
            checks++;
            errors++;
            $display("FAIL %s: condition not reached within %0d cycles", nm, budget);
        end
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : main
        int k;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_tx", TX, 1);
        chk("reset_busy", busy, 0);
        chk("reset_grant_active", grant_active, 0);
        chk("reset_grant_id", grant_id, 0);
        chk("reset_ready", req_ready, 0);
        rst_n = 1'b1;

        // single 0x55 from requester 0; lock stays held after the frame
        push_src(0, 8'h55);
        push_exp(2'd0, 8'h55);
        wait_until(0, 20, "a_start");
        wait_until(1, 60, "a_end");
        chk("a_lock_held", grant_active, 1);
        chk("a_owner", grant_id, 0);
        chk("a_ready", req_ready, 4'b0001);
        wait_until(2, 100, "a_release");

        // requesters 1..3, one line each, two rounds; rr_ptr starts at 1
        for (int r = 0; r < 2; r++) begin
            for (int i = 1; i < 4; i++) begin
                push_src(i, (r == 0) ? 8'(8'h30 + i) : 8'(8'h60 + i));
                push_src(i, 8'h0A);
            end
        end
        for (int r = 0; r < 2; r++) begin
            for (int i = 1; i < 4; i++) begin
                push_exp(2'(i), (r == 0) ? 8'(8'h30 + i) : 8'(8'h60 + i));
                push_exp(2'(i), 8'h0A);
            end
        end
        wait_until(2, 1000, "c_drain");

        // requesters 0 and 2 both send "AB\n"; rr_ptr is 0
        for (int i = 0; i < 3; i += 2) begin
            push_src(i, 8'h41);
            push_src(i, 8'h42);
            push_src(i, 8'h0A);
        end
        for (int i = 0; i < 3; i += 2) begin
            push_exp(2'(i), 8'h41);
            push_exp(2'(i), 8'h42);
            push_exp(2'(i), 8'h0A);
        end
        wait_until(2, 600, "b_drain");

        // owner 1 sends 0x41 then goes quiet; requester 3 waits for the lock
        push_src(1, 8'h41);
        push_exp(2'd1, 8'h41);
        push_exp(2'd3, 8'h33);
        wait_until(0, 20, "t_start");
        push_src(3, 8'h33);
        wait_until(1, 60, "t_end");
        k = 0;
        while (grant_active === 1'b1 && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk("t_release_cycles", k, LTO);
        @(negedge clk);
        chk("t_regrant_active", grant_active, 1);
        chk("t_regrant_id", grant_id, 3);
        wait_until(2, 200, "t_drain");

        // CR releases the lock at end of STOP even though owner 0 still has data
        push_src(0, 8'h0D);
        push_src(0, 8'h44);
        push_exp(2'd0, 8'h0D);
        push_exp(2'd1, 8'h31);
        push_exp(2'd0, 8'h44);
        wait_until(0, 20, "e_start");
        push_src(1, 8'h31);
        wait_until(1, 60, "e_end");
        chk("e_release_at_stop", grant_active, 0);
        @(negedge clk);
        chk("e_regrant_active", grant_active, 1);
        chk("e_regrant_id", grant_id, 1);
        wait_until(2, 400, "e_drain");

        // reset during data bit 3 of 0x96 (bit value 0)
        push_src(2, 8'h96);
        wait_until(0, 20, "r_start");
        repeat (17) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("r_tx", TX, 1);
        chk("r_busy", busy, 0);
        chk("r_grant_active", grant_active, 0);
        chk("r_ready", req_ready, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        push_src(2, 8'hC3);
        push_exp(2'd2, 8'hC3);
        wait_until(2, 200, "r_drain");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
